// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: groups the execute-stage request/response handshake and the
// data-memory port of the load/store unit into one bundle.
//   slave  modport - the load/store unit itself (takes requests, drives memory)
//   master modport - the environment: execute stage plus the data memory
// Signals:
//   req_valid/req_ready      request handshake
//   req_write/size/unsigned  access kind; req_addr byte address; req_wdata store data
//   resp_valid/resp_rdata    one-cycle completion pulse and extended load data
//   mem_rdaddress/mem_q      word read port (mem_q registered one cycle later)
//   mem_wraddress/mem_wren/mem_byteena/mem_data  word write port
interface dmem_lsu_if #(
  parameter int AW = 15
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic [AW-1:0] mem_rdaddress;
  logic [AW-1:0] mem_wraddress;
  logic          mem_wren;
  logic [3:0]    mem_byteena;
  logic [31:0]   mem_data;
  logic [31:0]   mem_q;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_q,
    output req_ready, resp_valid, resp_rdata,
           mem_rdaddress, mem_wraddress, mem_wren, mem_byteena, mem_data
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_q,
    input  req_ready, resp_valid, resp_rdata,
           mem_rdaddress, mem_wraddress, mem_wren, mem_byteena, mem_data
  );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit driving the CPU data-memory port.
// Accepts byte/half/word loads and stores, produces word addresses, byte
// enables and lane-aligned write data, and returns sign/zero-extended load
// data. Accesses straddling a word boundary become two word accesses.
// Ports:
//   clock - single clock for the unit and the memory port
//   reset - synchronous, active-high
//   bus   - dmem_lsu_if.slave: request/response handshake and memory port
module dmem_lsu #(
  parameter int AW = 15
) (
  input  logic       clock,
  input  logic       reset,
  dmem_lsu_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_LD0, S_LD1, S_LRSP, S_ST0A, S_ST0B, S_ST1A, S_ST1B, S_RSP
  } state_t;

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic          respValid_q, respValid_d;
  logic [31:0]   respRdata_q, respRdata_d;
  logic [AW-1:0] rdAddr_q, rdAddr_d;
  logic [AW-1:0] wrAddr_q, wrAddr_d;
  logic          wren_q, wren_d;
  logic [3:0]    byteena_q, byteena_d;
  logic [31:0]   data_q, data_d;
  logic [31:0]   q0_q, q0_d;

  logic          write_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [1:0]    off_q;
  logic [AW-1:0] w0_q;
  logic [31:0]   wdata_q;

  logic          accept;
  logic [1:0]    curSize, curOff;
  logic          curUns;
  logic [AW-1:0] curW0, curW1;
  logic [31:0]   curWdata;
  logic [3:0]    mask;
  logic [7:0]    m8;
  logic          split;
  logic [63:0]   stShift;
  logic [31:0]   lane0, lane1;
  logic [31:0]   q0, q1;
  logic [63:0]   ldShift;
  logic [31:0]   ldWord, ldExt;
  logic          unusedBits;

  assign accept = bus.req_valid & ready_q;

  // In IDLE the request fields come straight from the bus so the first memory
  // access can be set up in the accepting cycle; afterwards use the latched copy.
  always_comb begin
    curSize  = size_q;
    curOff   = off_q;
    curUns   = uns_q;
    curW0    = w0_q;
    curWdata = wdata_q;
    if (state_q == S_IDLE) begin
      curSize  = bus.req_size;
      curOff   = bus.req_addr[1:0];
      curUns   = bus.req_unsigned;
      curW0    = bus.req_addr[AW+1:2];
      curWdata = bus.req_wdata;
    end
  end

  // Byte-lane geometry across the two candidate words; the second word index
  // wraps naturally at the AW-bit boundary.
  always_comb begin
    unique case (curSize)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    m8      = {4'b0000, mask} << curOff;
    split   = |m8[7:4];
    curW1   = curW0 + {{(AW-1){1'b0}}, 1'b1};
    stShift = {32'b0, curWdata} << {curOff, 3'b000};
    lane0   = {{8{m8[3]}}, {8{m8[2]}}, {8{m8[1]}}, {8{m8[0]}}};
    lane1   = {{8{m8[7]}}, {8{m8[6]}}, {8{m8[5]}}, {8{m8[4]}}};
  end

  // Load merge: for a split load the first word was parked in q0_q and the
  // second word is on mem_q now; otherwise mem_q holds the only word.
  always_comb begin
    q0      = split ? q0_q : bus.mem_q;
    q1      = split ? bus.mem_q : 32'b0;
    ldShift = {q1, q0} >> {curOff, 3'b000};
    ldWord  = ldShift[31:0];
    unique case (curSize)
      2'b00:   ldExt = curUns ? {24'b0, ldWord[7:0]}  : {{24{ldWord[7]}}, ldWord[7:0]};
      2'b01:   ldExt = curUns ? {16'b0, ldWord[15:0]} : {{16{ldWord[15]}}, ldWord[15:0]};
      default: ldExt = ldWord;
    endcase
  end

  assign unusedBits = ^{bus.req_addr[31:AW+2], ldShift[63:32]};

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = bus.req_write ? S_ST0A : S_LD0;
      S_LD0:   state_d = split ? S_LD1 : S_LRSP;
      S_LD1:   state_d = S_LRSP;
      S_LRSP:  state_d = S_IDLE;
      S_ST0A:  state_d = S_ST0B;
      S_ST0B:  state_d = split ? S_ST1A : S_RSP;
      S_ST1A:  state_d = S_ST1B;
      S_ST1B:  state_d = S_RSP;
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the state being entered, so each
  // output lines up with the state it belongs to. A load's response appears
  // in the first IDLE cycle, so ready is withheld for that one cycle.
  always_comb begin
    ready_d     = (state_q == S_IDLE && !accept) || (state_q == S_RSP);
    respValid_d = (state_q == S_LRSP) || (state_d == S_RSP);
    respRdata_d = respRdata_q;
    rdAddr_d    = rdAddr_q;
    wrAddr_d    = wrAddr_q;
    wren_d      = 1'b0;
    byteena_d   = 4'b0000;
    data_d      = 32'b0;
    q0_d        = q0_q;

    if (state_q == S_LRSP) respRdata_d = ldExt;
    if (state_d == S_RSP)  respRdata_d = 32'b0;
    if (state_q == S_LD1)  q0_d = bus.mem_q;

    unique case (state_d)
      S_LD0: rdAddr_d = curW0;
      S_LD1: rdAddr_d = curW1;
      S_ST0A, S_ST0B: begin
        wren_d    = 1'b1;
        wrAddr_d  = curW0;
        byteena_d = m8[3:0];
        data_d    = stShift[31:0] & lane0;
      end
      S_ST1A, S_ST1B: begin
        wren_d    = 1'b1;
        wrAddr_d  = curW1;
        byteena_d = m8[7:4];
        data_d    = stShift[63:32] & lane1;
      end
      default: ;
    endcase
  end

  // State and output registers; request fields are captured on acceptance.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      respValid_q <= 1'b0;
      respRdata_q <= 32'b0;
      rdAddr_q    <= '0;
      wrAddr_q    <= '0;
      wren_q      <= 1'b0;
      byteena_q   <= 4'b0000;
      data_q      <= 32'b0;
      q0_q        <= 32'b0;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      off_q       <= 2'b00;
      w0_q        <= '0;
      wdata_q     <= 32'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      respValid_q <= respValid_d;
      respRdata_q <= respRdata_d;
      rdAddr_q    <= rdAddr_d;
      wrAddr_q    <= wrAddr_d;
      wren_q      <= wren_d;
      byteena_q   <= byteena_d;
      data_q      <= data_d;
      q0_q        <= q0_d;
      if (accept) begin
        write_q <= bus.req_write;
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        off_q   <= bus.req_addr[1:0];
        w0_q    <= bus.req_addr[AW+1:2];
        wdata_q <= bus.req_wdata;
      end
    end
  end

  assign bus.req_ready     = ready_q;
  assign bus.resp_valid    = respValid_q;
  assign bus.resp_rdata    = respRdata_q;
  assign bus.mem_rdaddress = rdAddr_q;
  assign bus.mem_wraddress = wrAddr_q;
  assign bus.mem_wren      = wren_q;
  assign bus.mem_byteena   = byteena_q;
  assign bus.mem_data      = data_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed testbench for dmem_lsu. Provides a read-merge-write
// data memory that commits a word only after two consecutive write-enable
// cycles on the same address, and walks through stores, loads, split
// accesses, address wrap and a mid-store reset abort.
module tb_dmem_lsu;
  localparam int AW = 15;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic memClear = 1'b1;
  int   checks = 0;
  int   failures = 0;

  dmem_lsu_if #(.AW(AW)) bus();

  dmem_lsu #(.AW(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural data memory: registered read, and a write that lands on the
  // second consecutive enabled cycle for the same word.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic [31:0]   memQ;
  logic          wrPend;
  logic [AW-1:0] wrPendAddr;
  logic [31:0]   merged;

  assign bus.mem_q = memQ;

  always @(posedge clock) begin
    if (memClear) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'b0;
      wrPend     <= 1'b0;
      wrPendAddr <= '0;
      memQ       <= 32'b0;
    end else begin
      if (bus.mem_wren) begin
        if (wrPend && wrPendAddr == bus.mem_wraddress) begin
          merged = mem[bus.mem_wraddress];
          for (int b = 0; b < 4; b++)
            if (bus.mem_byteena[b]) merged[8*b +: 8] = bus.mem_data[8*b +: 8];
          mem[bus.mem_wraddress] <= merged;
          wrPend <= 1'b0;
        end else begin
          wrPend     <= 1'b1;
          wrPendAddr <= bus.mem_wraddress;
        end
      end else begin
        wrPend <= 1'b0;
      end
      memQ <= mem[bus.mem_rdaddress];
    end
  end

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for ready, presents one request for a single cycle and
  // returns positioned in cycle 1 of the transaction.
  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wd, output bit ok);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      nextCycle();
      n++;
    end
    ok = (bus.req_ready === 1'b1);
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    nextCycle();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0000_0100;
    bus.req_wdata    = 32'h1234_5678;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      checks++;
      if (bus.req_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_ready c%0d: got %b expected 0", c, bus.req_ready);
      end
      checks++;
      if ({bus.mem_wren, bus.resp_valid} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL reset_wren_resp c%0d: got %b expected 00", c, {bus.mem_wren, bus.resp_valid});
      end
    end
    checks++;
    if ({bus.resp_rdata, bus.mem_data} !== 64'b0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h expected 0", {bus.resp_rdata, bus.mem_data});
    end
    checks++;
    if ({bus.mem_byteena, bus.mem_rdaddress, bus.mem_wraddress} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_addr_be: got %h %h %h expected 0", bus.mem_byteena, bus.mem_rdaddress, bus.mem_wraddress);
    end
    bus.req_valid = 1'b0;
    reset = 1'b0;
    nextCycle();
    nextCycle();
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", bus.req_ready);
    end
  endtask

  task automatic test_store(input string name, input logic [31:0] addr, input logic [1:0] sz,
                            input logic [31:0] wd, input bit split,
                            input logic [AW-1:0] wa0, input logic [3:0] be0, input logic [31:0] d0,
                            input logic [AW-1:0] wa1, input logic [3:0] be1, input logic [31:0] d1);
    bit ok;
    int last;
    logic expWren;
    logic [AW-1:0] expWa;
    logic [3:0] expBe;
    logic [31:0] expD;
    last = split ? 5 : 3;
    applyStimulus(1'b1, sz, 1'b0, addr, wd, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s accept: got ready timeout expected acceptance", name);
    end
    for (int c = 1; c <= last; c++) begin
      if (c > 1) nextCycle();
      expWren = (c < last);
      expWa   = (c <= 2) ? wa0 : wa1;
      expBe   = (c <= 2) ? be0 : be1;
      expD    = (c <= 2) ? d0 : d1;
      checks++;
      if (bus.mem_wren !== expWren) begin
        failures++;
        $display("[TB] FAIL %s wren c%0d: got %b expected %b", name, c, bus.mem_wren, expWren);
      end
      if (expWren) begin
        checks++;
        if (bus.mem_wraddress !== expWa || bus.mem_byteena !== expBe || bus.mem_data !== expD) begin
          failures++;
          $display("[TB] FAIL %s write c%0d: got %h/%b/%h expected %h/%b/%h", name, c,
                   bus.mem_wraddress, bus.mem_byteena, bus.mem_data, expWa, expBe, expD);
        end
      end
      checks++;
      if (bus.resp_valid !== (c == last) || bus.req_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s resp_ready c%0d: got %b/%b expected %b/0", name, c,
                 bus.resp_valid, bus.req_ready, (c == last));
      end
    end
    checks++;
    if (bus.resp_rdata !== 32'b0) begin
      failures++;
      $display("[TB] FAIL %s rdata: got %h expected 00000000", name, bus.resp_rdata);
    end
    nextCycle();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s after: got ready %b resp %b expected 1/0", name, bus.req_ready, bus.resp_valid);
    end
  endtask

  task automatic test_load(input string name, input logic [31:0] addr, input logic [1:0] sz,
                           input logic uns, input bit split,
                           input logic [AW-1:0] w0, input logic [AW-1:0] w1, input logic [31:0] exp);
    bit ok;
    int last;
    logic [AW-1:0] expRa;
    last = split ? 4 : 3;
    applyStimulus(1'b0, sz, uns, addr, 32'hFFFF_FFFF, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s accept: got ready timeout expected acceptance", name);
    end
    for (int c = 1; c <= last; c++) begin
      if (c > 1) nextCycle();
      expRa = (split && c >= 2) ? w1 : w0;
      checks++;
      if (bus.mem_rdaddress !== expRa || bus.mem_wren !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s rdaddr c%0d: got %h wren %b expected %h wren 0", name, c,
                 bus.mem_rdaddress, bus.mem_wren, expRa);
      end
      checks++;
      if (bus.resp_valid !== (c == last) || bus.req_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL %s resp_ready c%0d: got %b/%b expected %b/0", name, c,
                 bus.resp_valid, bus.req_ready, (c == last));
      end
    end
    checks++;
    if (bus.resp_rdata !== exp) begin
      failures++;
      $display("[TB] FAIL %s rdata: got %h expected %h", name, bus.resp_rdata, exp);
    end
    nextCycle();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s after: got ready %b resp %b expected 1/0", name, bus.req_ready, bus.resp_valid);
    end
  endtask

  // Split word store at 0x10A (words 0x042/0x043) cut by reset in cycle 3.
  task automatic test_abort();
    bit ok;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_010A, 32'hCAFE_F00D, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL abort accept: got ready timeout expected acceptance");
    end
    nextCycle();
    nextCycle();
    checks++;
    if (bus.mem_wren !== 1'b1 || bus.mem_wraddress !== 15'h0043) begin
      failures++;
      $display("[TB] FAIL abort c3_write: got %b/%h expected 1/0043", bus.mem_wren, bus.mem_wraddress);
    end
    reset = 1'b1;
    nextCycle();
    checks++;
    if (bus.mem_wren !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort c4: got wren %b resp %b ready %b expected 0/0/0",
               bus.mem_wren, bus.resp_valid, bus.req_ready);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL abort post c%0d: got resp %b ready %b expected 0/1", c, bus.resp_valid, bus.req_ready);
      end
    end
    checks++;
    if (mem[15'h0043] !== 32'h0000_0000) begin
      failures++;
      $display("[TB] FAIL abort w1_unchanged: got %h expected 00000000", mem[15'h0043]);
    end
    checks++;
    if (mem[15'h0042] !== 32'hF00D_1122) begin
      failures++;
      $display("[TB] FAIL abort w0_written: got %h expected F00D1122", mem[15'h0042]);
    end
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'b0;
    bus.req_wdata    = 32'b0;
    @(posedge clock);
    #1;
    nextCycle();
    memClear = 1'b0;

    test_reset();

    test_store("sw100", 32'h100, 2'b10, 32'hDEAD_BEEF, 1'b0,
               15'h040, 4'b1111, 32'hDEAD_BEEF, 15'h000, 4'b0000, 32'h0);
    test_load ("lw100", 32'h100, 2'b10, 1'b0, 1'b0, 15'h040, 15'h000, 32'hDEAD_BEEF);

    test_store("sb103", 32'h103, 2'b00, 32'h0000_00A5, 1'b0,
               15'h040, 4'b1000, 32'hA500_0000, 15'h000, 4'b0000, 32'h0);
    test_load ("lb103",  32'h103, 2'b00, 1'b0, 1'b0, 15'h040, 15'h000, 32'hFFFF_FFA5);
    test_load ("lbu103", 32'h103, 2'b00, 1'b1, 1'b0, 15'h040, 15'h000, 32'h0000_00A5);
    test_load ("lh102",  32'h102, 2'b01, 1'b0, 1'b0, 15'h040, 15'h000, 32'hFFFF_A5AD);
    test_load ("lhu102", 32'h102, 2'b01, 1'b1, 1'b0, 15'h040, 15'h000, 32'h0000_A5AD);

    test_store("swSplit", 32'h106, 2'b10, 32'h1122_3344, 1'b1,
               15'h041, 4'b1100, 32'h3344_0000, 15'h042, 4'b0011, 32'h0000_1122);
    test_load ("lwSplit", 32'h106, 2'b10, 1'b0, 1'b1, 15'h041, 15'h042, 32'h1122_3344);
    test_load ("lw101",   32'h101, 2'b10, 1'b0, 1'b1, 15'h040, 15'h041, 32'h00A5_ADBE);

    test_store("sh202", 32'h202, 2'b01, 32'hFFFF_1234, 1'b0,
               15'h080, 4'b1100, 32'h1234_0000, 15'h000, 4'b0000, 32'h0);
    test_store("sb201", 32'h201, 2'b00, 32'h7777_77C3, 1'b0,
               15'h080, 4'b0010, 32'h0000_C300, 15'h000, 4'b0000, 32'h0);
    test_load ("lw200", 32'h200, 2'b10, 1'b0, 1'b0, 15'h080, 15'h000, 32'h1234_C300);
    test_load ("lb201", 32'h201, 2'b00, 1'b0, 1'b0, 15'h080, 15'h000, 32'hFFFF_FFC3);

    test_store("shWrap", 32'h0001_FFFF, 2'b01, 32'h0000_BEEF, 1'b1,
               15'h7FFF, 4'b1000, 32'hEF00_0000, 15'h0000, 4'b0001, 32'h0000_00BE);
    test_load ("lhuWrap", 32'h0001_FFFF, 2'b01, 1'b1, 1'b1, 15'h7FFF, 15'h0000, 32'h0000_BEEF);
    test_load ("lhWrap",  32'h0001_FFFF, 2'b01, 1'b0, 1'b1, 15'h7FFF, 15'h0000, 32'hFFFF_BEEF);

    test_abort();
    test_load ("lw108", 32'h108, 2'b10, 1'b0, 1'b0, 15'h042, 15'h000, 32'hF00D_1122);
    test_load ("lw10C", 32'h10C, 2'b10, 1'b0, 1'b0, 15'h043, 15'h000, 32'h0000_0000);
    test_load ("lw10A", 32'h10A, 2'b10, 1'b0, 1'b1, 15'h042, 15'h043, 32'h0000_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that drives the CPU data memory port. It accepts byte, halfword and word requests from the execute stage through a valid/ready handshake. It generates word addresses, byte enables and lane-shifted write data for the memory. Load results come back sign- or zero-extended. Misaligned accesses that straddle a word boundary are split into two word accesses and merged.

## Interface
Parameters:
- AW, 15, memory word-address width; word index = req_addr[AW+1:2].

Ports:
- clock  in  1  single clock for the block and the memory port.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10/11 word.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
- req_addr  in  32  byte address; bits above AW+1 are ignored.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse: load data valid, or store complete.
- resp_rdata  out  32  extended load result; 0 after a store.
- mem_rdaddress  out  AW  read word address.
- mem_wraddress  out  AW  write word address.
- mem_wren  out  1  write enable.
- mem_byteena  out  4  byte enables; bit i covers data[8i+7:8i].
- mem_data  out  32  lane-aligned write data.
- mem_q  in  32  read data; registered by memory one cycle after mem_rdaddress with mem_wren=0.

## Operation
- Offset off = req_addr[1:0]; w0 = req_addr[AW+1:2]; w1 = w0+1 mod 2^AW (wraps from all-ones to 0).
- Masks: byte 0001, half 0011, word 1111; m8 = mask << off (8 bits).
- split = m8[7:4] != 0. Cases: half at off 3; word at off 1–3.
- Store, per accessed word k (k = 0 for w0, 1 for w1):
  - mem_byteena = m8[4k+3:4k].
  - mem_data = ({32'b0, wdata} << 8·off)[32k+31:32k].
  - Disabled lanes drive 0.
- Memory is read-merge-write. Each word write holds mem_wren=1 for exactly 2 consecutive cycles, with wraddress, byteena and data stable.
- Load: read w0, plus w1 when split. Form {q1,q0} >> 8·off (q1 = 0 if not split). Take the low 8/16/32 bits and extend per req_unsigned.
- All request fields are latched on acceptance. Inputs are ignored until IDLE.
- FSM:
  - IDLE → LD0 or ST0a on req_valid.
  - LD0 → LD1 if split, else LRSP.
  - LD1 → LRSP.
  - ST0a → ST0b.
  - ST0b → ST1a if split, else RSP.
  - ST1a → ST1b → RSP.
  - LRSP/RSP → IDLE.
- mem_wren is high only in ST states. mem_rdaddress holds the last read address otherwise.

## Timing
- Cycle 0 is the cycle where req_valid & req_ready are both high. All outputs are registered.
- Aligned load:
  - Cycle 1: rdaddress = w0.
  - Cycle 2: mem_q = mem[w0].
  - Cycle 3: resp_valid = 1 with resp_rdata.
- Split load:
  - Cycle 2: q0 captured, rdaddress = w1.
  - Cycle 4: response.
- Aligned store:
  - Cycles 1–2: wren = 1 on w0.
  - Cycle 3: resp_valid.
- Split store:
  - Cycles 1–2: w0.
  - Cycles 3–4: w1.
  - Cycle 5: resp_valid.
- req_ready is 0 from cycle 1 through the resp cycle. The next accept is possible the cycle after resp_valid.
- Reset values: state IDLE, req_ready 1 in the cycle after reset deasserts (0 while reset is high). resp_valid 0, resp_rdata 0, mem_wren 0, mem_byteena 0, mem_data 0, both addresses 0.
- Reset mid-operation aborts: the next cycle shows mem_wren = 0, and no resp_valid is issued. A split store aborted after ST0b leaves w0 written. This is accepted behaviour.

## Test plan
- Reset: hold reset 3 cycles with req_valid = 1. Required: all outputs 0 and no acceptance; req_ready = 1 the cycle after release.
- sw 0x100 = 0xDEADBEEF:
  - Cycles 1–2: wren = 1, wraddress 0x040, byteena 1111, data 0xDEADBEEF; ack in cycle 3.
  - Then lw 0x100: resp_rdata = 0xDEADBEEF in cycle 3.
- sb 0x103 = 0x000000A5:
  - Store: byteena 1000, data 0xA5000000.
  - lb 0x103 → 0xFFFFFFA5; lbu → 0x000000A5; lh 0x102 → 0xFFFFA5xx, with xx matching memory.
- Split sw 0x106 = 0x11223344:
  - Word 0x041: byteena 1100, data 0x33440000.
  - Word 0x042: byteena 0011, data 0x00001122; ack in cycle 5.
  - lw 0x106 → 0x11223344 in cycle 4.
- Wrap: sh at byte 0x1FFFF = 0xBEEF.
  - Word 0x7FFF: byteena 1000, data 0xEF000000.
  - Word 0x0000: byteena 0001, data 0x000000BE.
  - lhu at the same address → 0x0000BEEF.
- Abort: assert reset in cycle 3 of a split store. Required: wren = 0 the next cycle, no resp_valid, req_ready = 1 after release, word w1 unchanged.
